// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and constants for the RSA accelerator sequencers.
//   state_t     - modular-exponentiation sequencer states
//   MUL_OP_*    - encoding of the mul_op command bit
//   RSA_WIDTH   - default exponent / operand width
//   len_is_zero - decodes the length unit's "exponent was zero" code
package rsa_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    LEN,
    INIT,
    SQR,
    SQR_W,
    MUL,
    MUL_W,
    NXT,
    FIN
  } state_t;

  localparam logic MUL_OP_SQR = 1'b0;
  localparam logic MUL_OP_MUL = 1'b1;

  localparam int RSA_WIDTH = 64;

  // The length unit reports all-ones when it never found a set bit.
  function automatic logic len_is_zero(input logic [31:0] len);
    return &len;
  endfunction

endpackage

// File: rtl/modexp_seq.sv
// modexp_seq: left-to-right square-and-multiply sequencer.
// Latches an exponent, lets the serial bit-length unit find its MSB index,
// then walks the exponent from that MSB down to bit 0, issuing one square per
// bit and one extra multiply for every set bit to the modular multiplier.
//
// Ports:
//   clk, rstn     clock (rising edge), asynchronous active-low reset
//   start         request pulse, only honoured in IDLE (start beats abort)
//   abort         synchronous cancel, honoured in any state but IDLE/FIN
//   exponent      exponent, captured when start is accepted
//   busy          high while a run is in progress (low in IDLE and FIN)
//   done          one-cycle pulse on normal completion
//   op_count      multiplier commands issued in the current/last run
//   len_in        latched exponent, fed to the length unit
//   len_rstn      active-low re-arm of the length unit (rstn & ~arm)
//   len_en        length unit enable
//   len_length    MSB index from the length unit (all-ones: exponent==0)
//   len_end       length unit finished (level)
//   acc_init      one-cycle pulse: datapath loads accumulator with 1
//   mul_start     one-cycle multiplier command pulse
//   mul_op        0 square, 1 multiply by base; valid with mul_start
//   mul_done      multiplier completion pulse
//
// state | meaning
// IDLE  | waiting for start
// ARM   | length unit held in reset for one cycle, samples len_in
// LEN   | length unit running, waiting for len_end
// INIT  | accumulator loaded with 1
// SQR   | square command issued
// SQR_W | waiting for square to finish
// MUL   | multiply command issued
// MUL_W | waiting for multiply to finish
// NXT   | step to next lower exponent bit or finish
// FIN   | done pulse, back to IDLE
module modexp_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] exponent,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  op_count,
  output logic [WIDTH-1:0] len_in,
  output logic             len_rstn,
  output logic             len_en,
  input  logic [31:0]      len_length,
  input  logic             len_end,
  output logic             acc_init,
  output logic             mul_start,
  output logic             mul_op,
  input  logic             mul_done
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            zero_exp;
  logic            arm;

  // The length unit is re-armed through its own reset so it restarts from
  // a clean state and samples the freshly latched exponent.
  assign len_rstn = rstn & ~arm;

  // All outputs are registered: each one is loaded on the transition into
  // the state that owns it, so it is valid for exactly the cycles spent
  // in that state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      idx       <= '0;
      zero_exp  <= 1'b0;
      arm       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_count  <= '0;
      len_in    <= '0;
      len_en    <= 1'b0;
      acc_init  <= 1'b0;
      mul_start <= 1'b0;
      mul_op    <= MUL_OP_SQR;
    end else begin
      arm       <= 1'b0;
      acc_init  <= 1'b0;
      mul_start <= 1'b0;
      done      <= 1'b0;

      if (abort && (state != IDLE) && (state != FIN)) begin
        // Any in-flight multiplier op is simply abandoned; its late
        // mul_done lands in IDLE where it is ignored.
        state  <= IDLE;
        busy   <= 1'b0;
        len_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len_in   <= exponent;
              op_count <= '0;
              arm      <= 1'b1;
              busy     <= 1'b1;
              state    <= ARM;
            end
          end

          ARM: begin
            len_en <= 1'b1;
            state  <= LEN;
          end

          LEN: begin
            if (len_end) begin
              len_en   <= 1'b0;
              idx      <= len_length[IDXW-1:0];
              zero_exp <= len_is_zero(len_length);
              acc_init <= 1'b1;
              state    <= INIT;
            end
          end

          INIT: begin
            if (zero_exp) begin
              // Result is the freshly loaded 1; no commands needed.
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              // The first square of acc=1 is kept to keep the command
              // stream uniform for every bit.
              mul_start <= 1'b1;
              mul_op    <= MUL_OP_SQR;
              op_count  <= op_count + CNT_ONE;
              state     <= SQR;
            end
          end

          SQR: state <= SQR_W;

          SQR_W: begin
            if (mul_done) begin
              if (len_in[idx]) begin
                mul_start <= 1'b1;
                mul_op    <= MUL_OP_MUL;
                op_count  <= op_count + CNT_ONE;
                state     <= MUL;
              end else begin
                state <= NXT;
              end
            end
          end

          MUL: state <= MUL_W;

          MUL_W: begin
            if (mul_done) state <= NXT;
          end

          NXT: begin
            if (idx == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              idx       <= idx - IDX_ONE;
              mul_start <= 1'b1;
              mul_op    <= MUL_OP_SQR;
              op_count  <= op_count + CNT_ONE;
              state     <= SQR;
            end
          end

          FIN: state <= IDLE;

          default: begin
            busy   <= 1'b0;
            len_en <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modexp_seq.sv
// tb_modexp_seq: directed bench for modexp_seq with small behavioural models
// of the bit-length unit (len_end three cycles after enable) and the
// modular multiplier (mul_done after a programmable delay).
module tb_modexp_seq;

  localparam int WIDTH = 64;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] exponent = '0;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  op_count;
  logic [WIDTH-1:0] len_in;
  logic             len_rstn;
  logic             len_en;
  logic [31:0]      len_length = '0;
  logic             len_end = 1'b0;
  logic             acc_init;
  logic             mul_start;
  logic             mul_op;
  logic             mul_done = 1'b0;

  modexp_seq #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .exponent   (exponent),
    .busy       (busy),
    .done       (done),
    .op_count   (op_count),
    .len_in     (len_in),
    .len_rstn   (len_rstn),
    .len_en     (len_en),
    .len_length (len_length),
    .len_end    (len_end),
    .acc_init   (acc_init),
    .mul_start  (mul_start),
    .mul_op     (mul_op),
    .mul_done   (mul_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / model state, written only by the negedge process below.
  logic         clr = 1'b0;
  int           mdelay = 1;
  bit           rand_delay = 1'b0;
  int           n_cmd = 0, n_init = 0, n_done = 0, n_arm = 0;
  int           done_cyc = -1, mdone_cyc = -1;
  logic         done_busy = 1'b0;
  logic [127:0] op_log = '0;
  int           mcnt = 0;
  int           lcnt = 0;
  int           st_cyc = 0;

  always @(negedge clk) begin
    if (mul_done) mul_done = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mul_done  = 1'b1;
        mdone_cyc = cyc;
      end
    end
    if (mul_start) mcnt = rand_delay ? int'($urandom_range(1, 20)) : mdelay;
    if (clr) begin
      n_cmd = 0; n_init = 0; n_done = 0; n_arm = 0;
      op_log = '0; done_cyc = -1;
    end else begin
      if (mul_start) begin
        if (n_cmd < 128) op_log[n_cmd] = mul_op;
        n_cmd++;
      end
      if (acc_init) n_init++;
      if (done) begin
        n_done++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      if (rstn && !len_rstn) n_arm++;
    end
    if (!len_rstn) begin
      lcnt    = 0;
      len_end = 1'b0;
    end else if (len_en) begin
      if (lcnt == 2) len_end = 1'b1;
      else lcnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [WIDTH-1:0] e, input logic [31:0] l, input logic ab);
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    exponent   = e;
    len_length = l;
    @(posedge clk);
    #1;
    start  = 1'b1;
    abort  = ab;
    st_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int k = 0;
    while (n_done == 0 && k < maxc) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({tag, "_finished"}, n_done != 0, 1'b1);
    tick(2);
  endtask

  task automatic wait_cmds(input int n);
    int k = 0;
    while (n_cmd < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("cmd_wait", n_cmd >= n, 1'b1);
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_op_count", op_count, 0);
    chk("rst_len_in", len_in, 0);
    chk("rst_len_en", len_en, 1'b0);
    chk("rst_len_rstn", len_rstn, 1'b0);
    chk("rst_acc_init", acc_init, 1'b0);
    chk("rst_mul_start", mul_start, 1'b0);
    chk("rst_mul_op", mul_op, 1'b0);
    tick(2);
    rstn = 1'b1;
    #1;
    chk("rst_len_rstn_rel", len_rstn, 1'b1);
    tick(2);

    // Zero exponent; abort together with start is ignored.
    mdelay = 1;
    go(64'h0, 32'hFFFF_FFFF, 1'b1);
    chk("zero_start_wins", busy, 1'b1);
    wait_done("zero", 100);
    chk("zero_acc_init", n_init, 1);
    chk("zero_cmds", n_cmd, 0);
    chk("zero_op_count", op_count, 0);
    chk("zero_done_count", n_done, 1);
    chk("zero_busy_at_done", done_busy, 1'b0);
    // start, ARM, 3 LEN cycles, INIT, FIN: 4 + 3 cycles inclusive.
    chk("zero_latency", done_cyc - st_cyc, 6);
    chk("zero_arm_pulses", n_arm, 1);
    chk("zero_busy_after", busy, 1'b0);

    // exponent = 1: SQR, MUL
    go(64'h1, 32'd0, 1'b0);
    wait_done("e1", 200);
    chk("e1_cmds", n_cmd, 2);
    chk("e1_ops", op_log, 128'h2);
    chk("e1_op_count", op_count, 2);
    chk("e1_done_after_nxt", done_cyc - mdone_cyc, 2);
    chk("e1_done_count", n_done, 1);

    // exponent = 0x0B, random multiplier delays: S,M,S,S,M,S,M
    rand_delay = 1'b1;
    go(64'h0B, 32'd3, 1'b0);
    wait_done("e0b", 1000);
    rand_delay = 1'b0;
    chk("e0b_cmds", n_cmd, 7);
    chk("e0b_ops", op_log, 128'h52);
    chk("e0b_op_count", op_count, 7);

    // exponent = 2^63: 64 squares, the multiply follows the leading square
    go(64'h8000_0000_0000_0000, 32'd63, 1'b0);
    wait_done("msb", 3000);
    chk("msb_cmds", n_cmd, 65);
    chk("msb_ops", op_log, 128'h2);
    chk("msb_op_count", op_count, 65);

    // start while busy is ignored
    mdelay = 2;
    go(64'h0B, 32'd3, 1'b0);
    tick(8);
    exponent = 64'h5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("busy_start", 500);
    chk("busy_start_ops", op_log, 128'h52);
    chk("busy_start_op_count", op_count, 7);
    chk("busy_start_len_in", len_in, 64'h0B);
    chk("busy_start_arm", n_arm, 1);
    chk("busy_start_done_count", n_done, 1);

    // next start in IDLE is accepted: 5 = 101b -> S,M,S,S,M
    go(64'h5, 32'd2, 1'b0);
    wait_done("e5", 500);
    chk("e5_ops", op_log, 128'h12);
    chk("e5_op_count", op_count, 5);
    chk("e5_arm", n_arm, 1);
    chk("e5_len_in", len_in, 64'h5);

    // abort in SQR_W, stale mul_done three cycles after the command
    mdelay = 3;
    go(64'h0B, 32'd3, 1'b0);
    wait_cmds(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_mul_start", mul_start, 1'b0);
    chk("abort_op_count_hold", op_count, 1);
    tick(8);
    chk("abort_no_more_cmds", n_cmd, 1);
    chk("abort_no_done", n_done, 0);
    chk("abort_idle", busy, 1'b0);

    mdelay = 1;
    go(64'h1, 32'd0, 1'b0);
    chk("restart_op_count_clr", op_count, 0);
    wait_done("restart", 200);
    chk("restart_ops", op_log, 128'h2);
    chk("restart_op_count", op_count, 2);

    // asynchronous reset in MUL_W
    mdelay = 10;
    go(64'h1, 32'd0, 1'b0);
    wait_cmds(2);
    rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_op_count", op_count, 0);
    chk("arst_len_in", len_in, 0);
    chk("arst_len_en", len_en, 1'b0);
    chk("arst_len_rstn", len_rstn, 1'b0);
    chk("arst_mul_start", mul_start, 1'b0);
    chk("arst_mul_op", mul_op, 1'b0);
    chk("arst_acc_init", acc_init, 1'b0);
    tick(2);
    rstn = 1'b1;
    tick(15);
    chk("arst_stays_idle", busy, 1'b0);
    chk("arst_no_done", n_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
